// File: rtl/raster_cmd_sequencer_pkg.sv
// Shared types for the raster command sequencer: command opcodes, command record,
// vertex/colour types and the sequencer FSM states.
package raster_cmd_sequencer_pkg;

  typedef logic [15:0] rgb565_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } vertex_t;

  localparam int VERTEX_W = $bits(vertex_t);

  typedef enum logic [1:0] {
    RCMD_NOP       = 2'd0,
    RCMD_CLEAR     = 2'd1,
    RCMD_TRI       = 2'd2,
    RCMD_FRAME_END = 2'd3
  } cmd_op_t;

  typedef struct packed {
    cmd_op_t op;
    rgb565_t color;
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
  } raster_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRI,
    ST_CLEAR_DRAIN,
    ST_CLEAR_WAIT,
    ST_FRAME_DRAIN
  } seq_state_t;

endpackage

// File: rtl/raster_cmd_sequencer_fifo.sv
// Single-clock command FIFO; the head entry is readable combinationally so the
// sequencer can pop and decode a command in the same cycle.
module raster_cmd_sequencer_fifo
  import raster_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  raster_cmd_t            i_data,
  input  logic                   i_pop,
  output raster_cmd_t            o_data,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  raster_cmd_t   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/raster_cmd_sequencer.sv
// Command-driven scheduler in front of rasterizer_top (CLEAR/TRI/FRAME_END/NOP).
// Define RASTER_CMD_STATS_EN to add per-frame triangle and cycle statistics outputs.
module raster_cmd_sequencer
  import raster_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int CLEAR_GUARD = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [1:0]             i_cmd_op,
  input  logic [15:0]            i_cmd_color,
  input  logic [VERTEX_W-1:0]    i_cmd_v0,
  input  logic [VERTEX_W-1:0]    i_cmd_v1,
  input  logic [VERTEX_W-1:0]    i_cmd_v2,
  output logic [VERTEX_W-1:0]    o_v0,
  output logic [VERTEX_W-1:0]    o_v1,
  output logic [VERTEX_W-1:0]    o_v2,
  output logic                   o_tri_valid,
  input  logic                   i_tri_ready,
  input  logic                   i_rast_busy,
  output logic                   o_fb_clear,
  output logic [15:0]            o_fb_clear_color,
  input  logic                   i_fb_clearing,
  output logic                   o_frame_done,
  output logic [15:0]            o_frame_count,
  output logic [$clog2(DEPTH):0] o_fifo_level,
`ifdef RASTER_CMD_STATS_EN
  output logic [15:0]            o_stat_tri_count,
  output logic [31:0]            o_stat_frame_cycles,
`endif
  output logic                   o_idle
);

  localparam int GW = (CLEAR_GUARD < 1) ? 1 : $clog2(CLEAR_GUARD + 1);

  seq_state_t          r_state;
  logic [GW-1:0]       r_guard;
  rgb565_t             r_cmd_color;
  logic [VERTEX_W-1:0] r_v0, r_v1, r_v2;
  logic                r_tri_valid;
  logic                r_fb_clear;
  rgb565_t             r_fb_clear_color;
  logic                r_frame_done;
  logic [15:0]         r_frame_count;

  raster_cmd_t         w_push_cmd;
  raster_cmd_t         w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_quiet;
  logic                w_frame_fire;

  assign w_push_cmd = '{op:    cmd_op_t'(i_cmd_op),
                        color: i_cmd_color,
                        v0:    vertex_t'(i_cmd_v0),
                        v1:    vertex_t'(i_cmd_v1),
                        v2:    vertex_t'(i_cmd_v2)};

  raster_cmd_sequencer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (i_cmd_valid),
    .i_data  (w_push_cmd),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_level (o_fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_cmd_ready  = !w_full;
  assign w_pop        = (r_state == ST_IDLE) && !w_empty;
  assign w_quiet      = !i_rast_busy && i_tri_ready && !i_fb_clearing;
  assign w_frame_fire = (r_state == ST_FRAME_DRAIN) && w_quiet;
  assign o_idle       = w_empty && (r_state == ST_IDLE) && w_quiet;

  assign o_v0             = r_v0;
  assign o_v1             = r_v1;
  assign o_v2             = r_v2;
  assign o_tri_valid      = r_tri_valid;
  assign o_fb_clear       = r_fb_clear;
  assign o_fb_clear_color = r_fb_clear_color;
  assign o_frame_done     = r_frame_done;
  assign o_frame_count    = r_frame_count;

  // Clears wait for quiet so they never overwrite pixels of in-flight triangles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_guard          <= '0;
      r_cmd_color      <= '0;
      r_v0             <= '0;
      r_v1             <= '0;
      r_v2             <= '0;
      r_tri_valid      <= 1'b0;
      r_fb_clear       <= 1'b0;
      r_fb_clear_color <= '0;
      r_frame_done     <= 1'b0;
    end else begin
      r_fb_clear   <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_cmd_color <= w_head.color;
            case (w_head.op)
              RCMD_TRI: begin
                r_v0        <= w_head.v0;
                r_v1        <= w_head.v1;
                r_v2        <= w_head.v2;
                r_tri_valid <= 1'b1;
                r_state     <= ST_TRI;
              end
              RCMD_CLEAR:     r_state <= ST_CLEAR_DRAIN;
              RCMD_FRAME_END: r_state <= ST_FRAME_DRAIN;
              default:        r_state <= ST_IDLE;
            endcase
          end
        end
        ST_TRI: begin
          if (r_tri_valid && i_tri_ready) begin
            r_tri_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        ST_CLEAR_DRAIN: begin
          if (w_quiet) begin
            r_fb_clear_color <= r_cmd_color;
            r_fb_clear       <= 1'b1;
            r_guard          <= GW'(CLEAR_GUARD);
            r_state          <= ST_CLEAR_WAIT;
          end
        end
        // fb_clearing may rise a few cycles after the strobe; ignore it until the guard expires.
        ST_CLEAR_WAIT: begin
          if (r_guard != '0) begin
            r_guard <= r_guard - GW'(1);
          end else if (!i_fb_clearing) begin
            r_state <= ST_IDLE;
          end
        end
        ST_FRAME_DRAIN: begin
          if (w_frame_fire) begin
            r_frame_done <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_count <= '0;
    else        r_frame_count <= r_frame_count + 16'(w_frame_fire);
  end

`ifdef RASTER_CMD_STATS_EN
  logic [15:0] r_tri_run;
  logic [15:0] r_stat_tri;
  logic [31:0] r_cyc_run;
  logic [31:0] r_stat_cycles;
  logic        w_tri_hs;

  assign w_tri_hs            = (r_state == ST_TRI) && r_tri_valid && i_tri_ready;
  assign o_stat_tri_count    = r_stat_tri;
  assign o_stat_frame_cycles = r_stat_cycles;

  // Running counters are snapshotted and restarted on every frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tri_run     <= '0;
      r_stat_tri    <= '0;
      r_cyc_run     <= '0;
      r_stat_cycles <= '0;
    end else if (w_frame_fire) begin
      r_stat_tri    <= r_tri_run;
      r_tri_run     <= '0;
      r_stat_cycles <= r_cyc_run;
      r_cyc_run     <= 32'd1;
    end else begin
      if (w_tri_hs)        r_tri_run <= r_tri_run + 16'd1;
      if (r_cyc_run != '1) r_cyc_run <= r_cyc_run + 32'd1;
    end
  end
`endif

endmodule
